// File: rtl/lbist_ora_misr_pkg.sv
// -----------------------------------------------------------------------------
// lbist_pkg
// Shared LBIST definitions used by the output response analyzer and the
// pattern generator: the analyzer state encoding and the default MISR
// tap/seed constants.
// -----------------------------------------------------------------------------
package lbist_pkg;

    // Analyzer run states. The encoding is fixed so that it can be observed
    // on the debug state output and matched by external checkers.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPACT = 2'b01,
        COMPARE = 2'b10,
        DONE    = 2'b11
    } state_t;

    localparam int unsigned LBIST_BITS = 3;

    // Bit i set means sig[i] feeds the feedback XOR.
    localparam logic [LBIST_BITS-1:0] LBIST_TAPS = 3'b110;
    localparam logic [LBIST_BITS-1:0] LBIST_SEED = 3'b000;

endpackage

// File: rtl/lbist_ora_misr_misr_core.sv
// -----------------------------------------------------------------------------
// misr_core
// Multiple-input signature register: a plain shift register with XOR
// feedback into bit 0 and the response word XORed across all bits.
//
// Ports
//   clk   in   1     system clock, rising edge
//   rst   in   1     synchronous active-high reset, loads seed
//   load  in   1     load seed (has priority over en)
//   seed  in   BITS  value loaded on rst or load
//   en    in   1     compact resp this cycle
//   resp  in   BITS  response word
//   sig   out  BITS  current signature
// -----------------------------------------------------------------------------
module misr_core
    import lbist_pkg::*;
#(
    parameter int unsigned         BITS = LBIST_BITS,
    parameter logic [BITS-1:0]     TAPS = BITS'(LBIST_TAPS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [BITS-1:0] seed,
    input  logic            en,
    input  logic [BITS-1:0] resp,
    output logic [BITS-1:0] sig
);

    logic [BITS-1:0] sig_q;
    logic [BITS-1:0] sig_d;
    logic            fb;

    always_comb begin
        fb    = ^(sig_q & TAPS);
        sig_d = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (en) begin
            // Shift left, feedback enters at bit 0, MSB falls off.
            sig_d = {sig_q[BITS-2:0], fb} ^ resp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= seed;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/lbist_ora_misr.sv
// -----------------------------------------------------------------------------
// lbist_ora_misr
// LBIST output response analyzer. Compacts CUT responses into a MISR while
// a run is active, and on the generator's end-of-sequence flag compares the
// final signature against GOLDEN and reports pass/fail.
//
// Optional feature: define ORA_TIMEOUT_EN to add a compacted-response
// counter that aborts a run (done=1, pass=0, timeout=1) after MAX_PATTERNS
// responses without end_in.
//
// Handshake: there is no backpressure. A response is consumed on every
// rising edge where the analyzer is compacting and valid=1; end_in on that
// same edge closes the run after that response is compacted.
//
// Ports
//   clk        in   1     system clock, rising edge
//   rst        in   1     synchronous active-high reset
//   start      in   1     begin a run (honoured in IDLE or DONE)
//   valid      in   1     resp carries a response
//   resp       in   BITS  CUT response word
//   end_in     in   1     end of pattern sequence
//   signature  out  BITS  current MISR contents
//   busy       out  1     run in progress (COMPACT or COMPARE)
//   done       out  1     run finished
//   pass       out  1     final signature matched GOLDEN (valid with done)
//   timeout    out  1     run aborted by the pattern limit (ORA_TIMEOUT_EN)
//   state_dbg  out  2     current state, for observation only
// -----------------------------------------------------------------------------
module lbist_ora_misr
    import lbist_pkg::*;
#(
    parameter int unsigned     BITS         = LBIST_BITS,
    parameter logic [BITS-1:0] TAPS         = BITS'(LBIST_TAPS),
    parameter logic [BITS-1:0] SEED         = BITS'(LBIST_SEED),
    parameter logic [BITS-1:0] GOLDEN       = BITS'(3'b111)
`ifdef ORA_TIMEOUT_EN
    ,
    parameter int unsigned     MAX_PATTERNS = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            valid,
    input  logic [BITS-1:0] resp,
    input  logic            end_in,
    output logic [BITS-1:0] signature,
    output logic            busy,
    output logic            done,
    output logic            pass,
`ifdef ORA_TIMEOUT_EN
    output logic            timeout,
`endif
    output state_t          state_dbg
);

    state_t state_q;
    state_t state_d;
    logic   done_q;
    logic   done_d;
    logic   pass_q;
    logic   pass_d;

    logic   run_start;
    logic   compact_en;
    logic   timeout_hit;

    // start only matters when no run is in flight.
    assign run_start  = start && ((state_q == IDLE) || (state_q == DONE));
    assign compact_en = (state_q == COMPACT) && valid;

    misr_core #(
        .BITS (BITS),
        .TAPS (TAPS)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (run_start),
        .seed (SEED),
        .en   (compact_en),
        .resp (resp),
        .sig  (signature)
    );

`ifdef ORA_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_PATTERNS + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_q;
    logic             timeout_d;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // The limit is reached by the response compacted on this edge; end_in on
    // the same edge takes precedence and runs the normal compare.
    assign timeout_hit = compact_en && !end_in
                         && (cnt_inc == CNT_W'(MAX_PATTERNS));

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (run_start) begin
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            if (compact_en) begin
                cnt_d = cnt_inc;
            end
            if (timeout_hit) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COMPACT;
                end
            end
            COMPACT: begin
                if (end_in) begin
                    state_d = COMPARE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            COMPARE: begin
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d = COMPACT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy      = (state_q == COMPACT) || (state_q == COMPARE);
        state_dbg = state_q;
    end

    // Registered result flags. In COMPARE the MISR already holds the final
    // signature, including any response compacted on the end_in edge.
    always_comb begin
        done_d = done_q;
        pass_d = pass_q;
        if (run_start) begin
            done_d = 1'b0;
            pass_d = 1'b0;
        end else if (state_q == COMPARE) begin
            done_d = 1'b1;
            pass_d = (signature == GOLDEN);
        end else if (timeout_hit) begin
            done_d = 1'b1;
            pass_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    assign done = done_q;
    assign pass = pass_q;

endmodule
